frc_burst_unpacker: RTL and testbench

FRC_BURST_UNPACKER -- requirements
Module: frc_burst_unpacker

---
 rtl/MD_pkg.sv | 16 +
 rtl/frc_rx_beat_fifo.sv | 66 ++++++
 rtl/frc_burst_unpacker.sv | 157 +++++++++++++++
 tb/tb_frc_burst_unpacker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared widths and FSM state type for the force-beat receive path.
// Beat = NUM_SUB_PACKETS sub-packets, highest slot in the top bits.
package MD_pkg;

  localparam int SUB_PACKET_WIDTH = 128;
  localparam int NUM_SUB_PACKETS  = 4;
  localparam int AXIS_TDATA_WIDTH = SUB_PACKET_WIDTH * NUM_SUB_PACKETS;
  localparam int NODE_ID_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_LAST = 2'd2
  } unpack_state_e;

endpackage

// File: rtl/frc_rx_beat_fifo.sv
// Input beat FIFO holding beat data plus its source node id.
// ready is registered from the next-cycle count.
module frc_rx_beat_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 512,
  parameter int IW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic [IW-1:0]          push_src,
  input  logic                   pop,
  output logic [DW-1:0]          head_data,
  output logic [IW-1:0]          head_src,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ready
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_data [DEPTH];
  logic [IW-1:0] mem_src  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_nxt;

  assign head_data = mem_data[rd_ptr];
  assign head_src  = mem_src[rd_ptr];
  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)
      cnt_nxt = count + 1'b1;
    else if (!push && pop)
      cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_src[wr_ptr]  <= push_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      ready <= cnt_nxt != (AW+1)'(DEPTH);
    end
  end

endmodule

// File: rtl/frc_burst_unpacker.sv
// Unpacks force beats into sub-packets, slot 3 first; a flag in slot 0 ends a burst.
// Optional debug counters: define FRC_RX_DEBUG_EN.
module frc_burst_unpacker
  import MD_pkg::*;
#(
  parameter int BEAT_FIFO_DEPTH = 4,
  parameter int LAST_FLAG_BIT   = 96
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_frc_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] i_frc_tdata,
  input  logic [NODE_ID_WIDTH-1:0]    i_src_id,
  output logic                        o_frc_tready,
  output logic                        o_frc_pkt_valid,
  output logic [SUB_PACKET_WIDTH-1:0] o_frc_pkt,
  output logic [NODE_ID_WIDTH-1:0]    o_src_id,
  input  logic                        i_frc_pkt_ready,
  output logic                        o_last_frc_received,
  output logic                        o_burst_active
`ifdef FRC_RX_DEBUG_EN
  ,
  output logic [31:0]                 o_debug_beat_cnt,
  output logic [31:0]                 o_debug_pkt_cnt
`endif
);

  localparam int CW = $clog2(BEAT_FIFO_DEPTH) + 1;
  localparam logic [SUB_PACKET_WIDTH-1:0] FLAG_MASK =
    {{(SUB_PACKET_WIDTH-1){1'b0}}, 1'b1} << LAST_FLAG_BIT;

  logic                        push;
  logic                        pop;
  logic [AXIS_TDATA_WIDTH-1:0] head_data;
  logic [NODE_ID_WIDTH-1:0]    head_src;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic                        unused;

  unpack_state_e               state;
  logic [AXIS_TDATA_WIDTH-1:0] beat_q;
  logic [NODE_ID_WIDTH-1:0]    src_q;
  logic [1:0]                  idx_q;

  logic [AXIS_TDATA_WIDTH-1:0] cur_beat;
  logic [NODE_ID_WIDTH-1:0]    cur_src;
  logic [1:0]                  cur_idx;
  logic [SUB_PACKET_WIDTH-1:0] slot;
  logic [SUB_PACKET_WIDTH-1:0] pkt_clr;
  logic                        out_free;
  logic                        scanning;
  logic                        step;
  logic                        load;
  logic                        slot_last;
  logic                        last_fire;

  assign push   = i_frc_tvalid && o_frc_tready;
  assign unused = &{1'b0, fifo_full, fifo_count};

  frc_rx_beat_fifo #(
    .DEPTH (BEAT_FIFO_DEPTH),
    .DW    (AXIS_TDATA_WIDTH),
    .IW    (NODE_ID_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (i_frc_tdata),
    .push_src  (i_src_id),
    .pop       (pop),
    .head_data (head_data),
    .head_src  (head_src),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ready     (o_frc_tready)
  );

  // Slot 3 is scanned straight off the FIFO head on the pop cycle.
  assign out_free  = !o_frc_pkt_valid || i_frc_pkt_ready;
  assign scanning  = (state == ST_SCAN)
                  || (state == ST_IDLE && !fifo_empty);
  assign step      = scanning && out_free;
  assign pop       = state == ST_IDLE && !fifo_empty && out_free;
  assign cur_beat  = (state == ST_SCAN) ? beat_q : head_data;
  assign cur_src   = (state == ST_SCAN) ? src_q : head_src;
  assign cur_idx   = (state == ST_SCAN) ? idx_q : 2'd3;
  assign slot      = cur_beat[SUB_PACKET_WIDTH*int'(cur_idx)
                              +: SUB_PACKET_WIDTH];
  assign pkt_clr   = slot & ~FLAG_MASK;
  assign load      = step && (pkt_clr != '0);
  assign slot_last = slot[LAST_FLAG_BIT] && cur_idx == 2'd0;
  assign last_fire = state == ST_LAST && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      beat_q <= '0;
      src_q  <= '0;
      idx_q  <= '0;
    end else if (step) begin
      if (state == ST_IDLE) begin
        beat_q <= head_data;
        src_q  <= head_src;
      end
      if (cur_idx == 2'd0) begin
        state <= slot_last ? ST_LAST : ST_IDLE;
      end else begin
        state <= ST_SCAN;
        idx_q <= cur_idx - 2'd1;
      end
    end else if (last_fire) begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frc_pkt_valid     <= 1'b0;
      o_frc_pkt           <= '0;
      o_src_id            <= '0;
      o_last_frc_received <= 1'b0;
      o_burst_active      <= 1'b0;
    end else begin
      if (load) begin
        o_frc_pkt_valid <= 1'b1;
        o_frc_pkt       <= pkt_clr;
        o_src_id        <= cur_src;
      end else if (i_frc_pkt_ready) begin
        o_frc_pkt_valid <= 1'b0;
      end
      if (last_fire)
        o_src_id <= src_q;
      o_last_frc_received <= last_fire;
      if (push)
        o_burst_active <= 1'b1;
      else if (last_fire)
        o_burst_active <= 1'b0;
    end
  end

`ifdef FRC_RX_DEBUG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_debug_beat_cnt <= '0;
      o_debug_pkt_cnt  <= '0;
    end else begin
      if (push)
        o_debug_beat_cnt <= o_debug_beat_cnt + 32'd1;
      if (o_frc_pkt_valid && i_frc_pkt_ready)
        o_debug_pkt_cnt <= o_debug_pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frc_burst_unpacker.sv
// Directed bench for frc_burst_unpacker; inputs driven and outputs
// sampled on the falling edge.
module tb_frc_burst_unpacker;
  import MD_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        i_frc_tvalid = 1'b0;
  logic [AXIS_TDATA_WIDTH-1:0] i_frc_tdata = '0;
  logic [NODE_ID_WIDTH-1:0]    i_src_id = '0;
  logic                        o_frc_tready;
  logic                        o_frc_pkt_valid;
  logic [SUB_PACKET_WIDTH-1:0] o_frc_pkt;
  logic [NODE_ID_WIDTH-1:0]    o_src_id;
  logic                        i_frc_pkt_ready = 1'b1;
  logic                        o_last_frc_received;
  logic                        o_burst_active;
`ifdef FRC_RX_DEBUG_EN
  logic [31:0]                 dbg_beats;
  logic [31:0]                 dbg_pkts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frc_burst_unpacker dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_frc_tvalid        (i_frc_tvalid),
    .i_frc_tdata         (i_frc_tdata),
    .i_src_id            (i_src_id),
    .o_frc_tready        (o_frc_tready),
    .o_frc_pkt_valid     (o_frc_pkt_valid),
    .o_frc_pkt           (o_frc_pkt),
    .o_src_id            (o_src_id),
    .i_frc_pkt_ready     (i_frc_pkt_ready),
    .o_last_frc_received (o_last_frc_received),
    .o_burst_active      (o_burst_active)
`ifdef FRC_RX_DEBUG_EN
    ,
    .o_debug_beat_cnt    (dbg_beats),
    .o_debug_pkt_cnt     (dbg_pkts)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  function automatic logic [127:0] pk(input int i, input int s);
    return {16'hBEE0, 8'(i), 7'(s), 1'b0, 64'h0, 32'(i*16+s+1)};
  endfunction

  function automatic logic [511:0] full_beat(input int i);
    return {pk(i,3), pk(i,2), pk(i,1), pk(i,0)};
  endfunction

  task automatic send(input logic [511:0] b, input logic [7:0] s);
    chk("tready_before_send", o_frc_tready, 1);
    i_frc_tvalid = 1'b1;
    i_frc_tdata  = b;
    i_src_id     = s;
    nx();
    i_frc_tvalid = 1'b0;
  endtask

  task automatic out_idle(input string tag);
    chk(tag, {o_frc_pkt_valid, o_last_frc_received}, 0);
  endtask

  logic [127:0] flag;
  logic [127:0] zero128;
  int           acc;
  int           got;
  bit           take;
  bit           low_seen;

  initial begin
    flag    = 128'd1 << 96;
    zero128 = '0;

    // reset state
    nx(); nx();
    chk("rst_valid", o_frc_pkt_valid, 0);
    chk("rst_pkt", o_frc_pkt, 0);
    chk("rst_src", o_src_id, 0);
    chk("rst_last", o_last_frc_received, 0);
    chk("rst_burst", o_burst_active, 0);
    chk("rst_tready", o_frc_tready, 0);
    rst_n = 1'b1;
    #1 chk("tready_pre_edge", o_frc_tready, 0);
    nx();
    chk("tready_after_rst", o_frc_tready, 1);

    // full beat, four packets back to back from N+2
    send(full_beat(1), 8'd1);
    chk("t1_burst", o_burst_active, 1);
    out_idle("t1_n1");
    nx();
    for (int s = 3; s >= 0; s--) begin
      chk("t1_valid", o_frc_pkt_valid, 1);
      chk("t1_pkt", o_frc_pkt, pk(1, s));
      chk("t1_src", o_src_id, 1);
      chk("t1_nolast", o_last_frc_received, 0);
      nx();
    end
    out_idle("t1_end");

    // two empty slots, flag in slot 0, src 5
    send({zero128, zero128, pk(2,1), pk(2,0) | flag}, 8'd5);
    out_idle("t2_n1");
    nx(); out_idle("t2_n2");
    nx(); out_idle("t2_n3");
    nx();
    chk("t2_p1_valid", o_frc_pkt_valid, 1);
    chk("t2_p1", o_frc_pkt, pk(2,1));
    chk("t2_p1_src", o_src_id, 5);
    nx();
    chk("t2_p0_valid", o_frc_pkt_valid, 1);
    chk("t2_p0", o_frc_pkt, pk(2,0));
    chk("t2_p0_nolast", o_last_frc_received, 0);
    chk("t2_p0_burst", o_burst_active, 1);
    nx();
    chk("t2_last", o_last_frc_received, 1);
    chk("t2_last_src", o_src_id, 5);
    chk("t2_burst_fall", o_burst_active, 0);
    chk("t2_novalid", o_frc_pkt_valid, 0);
    nx();
    chk("t2_last_pulse1", o_last_frc_received, 0);

    // flag-only beat
    send({zero128, zero128, zero128, flag}, 8'd7);
    chk("t3_burst", o_burst_active, 1);
    for (int c = 2; c <= 5; c++) begin
      nx();
      out_idle("t3_scan");
    end
    nx();
    chk("t3_last", o_last_frc_received, 1);
    chk("t3_src", o_src_id, 7);
    chk("t3_burst_fall", o_burst_active, 0);
    chk("t3_novalid", o_frc_pkt_valid, 0);
    nx();

    // flag in slot 2 is not an end marker, cleared on output
    send({pk(4,3), pk(4,2) | flag, zero128, zero128}, 8'd2);
    nx();
    chk("t4_p3", o_frc_pkt, pk(4,3));
    nx();
    chk("t4_p2_valid", o_frc_pkt_valid, 1);
    chk("t4_p2", o_frc_pkt, pk(4,2));
    nx(); out_idle("t4_n4");
    nx(); out_idle("t4_n5");
    nx(); out_idle("t4_n6");
    chk("t4_burst", o_burst_active, 1);

    // downstream stall with 5 beats offered
    i_frc_pkt_ready = 1'b0;
    acc = 0;
    low_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 5) begin
        i_frc_tvalid = 1'b1;
        i_frc_tdata  = full_beat(10 + acc);
        i_src_id     = 8'd3;
      end else begin
        i_frc_tvalid = 1'b0;
      end
      take = i_frc_tvalid && o_frc_tready;
      nx();
      if (take) acc++;
      if (!o_frc_tready) low_seen = 1;
      if (c >= 1) begin
        chk("t5_hold_valid", o_frc_pkt_valid, 1);
        chk("t5_hold_pkt", o_frc_pkt, pk(10,3));
      end
    end
    i_frc_tvalid = 1'b0;
    chk("t5_accepted", acc, 5);
    chk("t5_tready_low", o_frc_tready, 0);
    chk("t5_low_seen", low_seen, 1);
    i_frc_pkt_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 20; c++) begin
      if (o_frc_pkt_valid) begin
        chk("t5_drain", o_frc_pkt, pk(10 + got/4, 3 - got%4));
        got++;
      end
      nx();
    end
    chk("t5_drained", got, 20);
    nx(); nx();
    chk("t5_tready_back", o_frc_tready, 1);

    // reset mid-scan
    send(full_beat(20), 8'd4);
    nx(); nx();
    chk("t6_mid_valid", o_frc_pkt_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_frc_pkt_valid, 0);
    chk("t6_rst_pkt", o_frc_pkt, 0);
    chk("t6_rst_src", o_src_id, 0);
    chk("t6_rst_last", o_last_frc_received, 0);
    chk("t6_rst_burst", o_burst_active, 0);
    chk("t6_rst_tready", o_frc_tready, 0);
    nx();
    rst_n = 1'b1;
    nx();
    chk("t6_tready", o_frc_tready, 1);
    out_idle("t6_no_pulse");
    send({pk(21,3), pk(21,2), pk(21,1), pk(21,0) | flag}, 8'd9);
    nx();
    for (int s = 3; s >= 0; s--) begin
      chk("t6_valid", o_frc_pkt_valid, 1);
      chk("t6_pkt", o_frc_pkt, pk(21, s));
      chk("t6_src", o_src_id, 9);
      nx();
    end
    chk("t6_last", o_last_frc_received, 1);
    chk("t6_last_src", o_src_id, 9);
    chk("t6_burst_fall", o_burst_active, 0);
    nx();

`ifdef FRC_RX_DEBUG_EN
    send(full_beat(30), 8'd1);
    send(full_beat(31), 8'd1);
    for (int c = 0; c < 12; c++) nx();
    chk("dbg_beats", dbg_beats, 3);
    chk("dbg_pkts", dbg_pkts, 12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
